// File: rtl/memoria_dados_param.sv
// ---------------------------------------------------------------------------
// memoria_dados_param
// Parametrised data memory for the processor datapath.
// - Synchronous write, registered read (1-cycle latency) with a valid strobe.
// - Hardware clear sweep: after reset release, or on a clear command, every
//   word is written with zero, one word per clock, while "ocupado" is high.
//   Requests are ignored during the sweep.
// - Accesses with label >= PROFUNDIDADE never touch the array: writes are
//   dropped and reads return zero (still with dado_valido).
//
// Optional feature macro: MEMO_ERRO_EN
//   defined   -> "erro" pulses for one cycle on an accepted out-of-range access
//   undefined -> "erro" is tied to 0
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   label        in   [LARGURA_END]  word address
//   dado         in   [LARGURA_DADO] write data
//   EscrMemo     in   write request
//   LerMemo      in   read request
//   limpar       in   clear request (single-cycle pulse is enough)
//   dadoEscrito  out  [LARGURA_DADO] registered read data
//   dado_valido  out  one-cycle strobe when dadoEscrito is updated by a read
//   ocupado      out  clear sweep in progress
//   erro         out  out-of-range access flag
// ---------------------------------------------------------------------------
module memoria_dados_param #(
    parameter int LARGURA_DADO = 8,
    parameter int LARGURA_END  = 8,
    parameter int PROFUNDIDADE = 24
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [LARGURA_END-1:0]  label,
    input  logic [LARGURA_DADO-1:0] dado,
    input  logic                    EscrMemo,
    input  logic                    LerMemo,
    input  logic                    limpar,
    output logic [LARGURA_DADO-1:0] dadoEscrito,
    output logic                    dado_valido,
    output logic                    ocupado,
    output logic                    erro
);

    localparam int LARGURA_CNT = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;
    localparam logic [LARGURA_CNT-1:0] ULTIMO = LARGURA_CNT'(PROFUNDIDADE - 1);
    localparam logic [LARGURA_END:0]   LIMITE = (LARGURA_END + 1)'(PROFUNDIDADE);

    typedef enum logic [0:0] {
        LIMPANDO = 1'b0,
        OCIOSO   = 1'b1
    } estado_t;

    estado_t                 r_estado;
    logic [LARGURA_CNT-1:0]  r_cnt;
    logic [LARGURA_DADO-1:0] r_memo [PROFUNDIDADE];
    logic [LARGURA_DADO-1:0] r_dado_lido;
    logic                    r_valido;
    logic                    r_ocupado;

    logic                    w_no_intervalo;
    logic [LARGURA_CNT-1:0]  w_idx;
    logic                    w_aceita;
    logic                    w_escreve;
    logic                    w_le;
    logic                    w_mem_we;
    logic [LARGURA_CNT-1:0]  w_mem_addr;
    logic [LARGURA_DADO-1:0] w_mem_wdata;
    logic [LARGURA_DADO-1:0] w_dado_lido;

    // Extra leading zero bit keeps the compare valid when PROFUNDIDADE == 2^LARGURA_END.
    assign w_no_intervalo = ({1'b0, label} < LIMITE);

    // Out-of-range labels are folded to 0 so the array is never indexed past its end.
    assign w_idx = w_no_intervalo ? label[LARGURA_CNT-1:0] : '0;

    // A request is accepted only when idle and not overridden by a clear.
    assign w_aceita  = (r_estado == OCIOSO) && !limpar;
    assign w_escreve = w_aceita && EscrMemo && w_no_intervalo;
    assign w_le      = w_aceita && LerMemo;

    // Old contents are sampled here before the write lands, giving read-before-write.
    assign w_dado_lido = w_no_intervalo ? r_memo[w_idx] : '0;

    // Single array write port, shared between the clear sweep and user writes.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        if (r_estado == LIMPANDO) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = r_cnt;
            w_mem_wdata = '0;
        end else if (w_escreve) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = w_idx;
            w_mem_wdata = dado;
        end else begin
            w_mem_we    = 1'b0;
            w_mem_addr  = '0;
            w_mem_wdata = '0;
        end
    end

    // Storage array; no reset, contents are cleared by the sweep instead.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_memo[w_mem_addr] <= w_mem_wdata;
        end
    end

    // Control state machine with registered read data, valid strobe and busy flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_estado    <= LIMPANDO;
            r_cnt       <= '0;
            r_dado_lido <= '0;
            r_valido    <= 1'b0;
            r_ocupado   <= 1'b1;
        end else begin
            r_valido <= 1'b0;
            case (r_estado)
                LIMPANDO: begin
                    if (r_cnt == ULTIMO) begin
                        r_estado  <= OCIOSO;
                        r_ocupado <= 1'b0;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= r_cnt + LARGURA_CNT'(1);
                    end
                end
                OCIOSO: begin
                    if (limpar) begin
                        r_estado  <= LIMPANDO;
                        r_cnt     <= '0;
                        r_ocupado <= 1'b1;
                    end else if (w_le) begin
                        r_dado_lido <= w_dado_lido;
                        r_valido    <= 1'b1;
                    end
                end
                default: begin
                    r_estado  <= LIMPANDO;
                    r_cnt     <= '0;
                    r_ocupado <= 1'b1;
                end
            endcase
        end
    end

    assign dadoEscrito = r_dado_lido;
    assign dado_valido = r_valido;
    assign ocupado     = r_ocupado;

`ifdef MEMO_ERRO_EN
    logic r_erro;

    // One-cycle flag for an accepted access whose label lies beyond the array.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_erro <= 1'b0;
        end else begin
            r_erro <= w_aceita && (EscrMemo || LerMemo) && !w_no_intervalo;
        end
    end

    assign erro = r_erro;
`else
    assign erro = 1'b0;
`endif

endmodule

// File: tb/tb_memoria_dados_param.sv
`timescale 1ns/1ps
module tb_memoria_dados_param;

    localparam int D8  = 24;
    localparam int D16 = 64;
`ifdef MEMO_ERRO_EN
    localparam bit ERRO_EN = 1'b1;
`else
    localparam bit ERRO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [7:0]  label_a, dado_a, q_a;
    logic        we_a, re_a, clr_a, v_a, busy_a, err_a;
    logic [7:0]  label_b;
    logic [15:0] dado_b, q_b;
    logic        we_b, re_b, clr_b, v_b, busy_b, err_b;

    memoria_dados_param dut_a (
        .clk(clk), .reset(reset), .label(label_a), .dado(dado_a),
        .EscrMemo(we_a), .LerMemo(re_a), .limpar(clr_a),
        .dadoEscrito(q_a), .dado_valido(v_a), .ocupado(busy_a), .erro(err_a)
    );

    memoria_dados_param #(.LARGURA_DADO(16), .LARGURA_END(8), .PROFUNDIDADE(D16)) dut_b (
        .clk(clk), .reset(reset), .label(label_b), .dado(dado_b),
        .EscrMemo(we_b), .LerMemo(re_b), .limpar(clr_b),
        .dadoEscrito(q_b), .dado_valido(v_b), .ocupado(busy_b), .erro(err_b)
    );

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } rd_t;

    rd_t         rdq_a[$], rdq_b[$];
    int          errq_a[$], errq_b[$];
    int          cyc = 0;
    int          tests = 0, fails = 0;
    logic [7:0]  mem_a [D8];
    logic [15:0] mem_b [D16];
    int          left_a = 0, left_b = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: samples 2 time units after each rising edge and pops expectations.
    rd_t it;
    bit  e;
    always begin
        @(posedge clk);
        #2;
        if (v_a) begin
            if (rdq_a.size() > 0 && rdq_a[0].cyc < cyc) begin
                it = rdq_a.pop_front();
                chk("rd_data_a", {24'h0, q_a}, {16'h0, it.data});
            end else begin
                chk("unexpected_valid_a", {31'h0, v_a}, 32'h0);
            end
        end else if (rdq_a.size() > 0 && rdq_a[0].cyc < cyc) begin
            void'(rdq_a.pop_front());
            chk("missing_valid_a", {31'h0, v_a}, 32'h1);
        end
        if (v_b) begin
            if (rdq_b.size() > 0 && rdq_b[0].cyc < cyc) begin
                it = rdq_b.pop_front();
                chk("rd_data_b", {16'h0, q_b}, {16'h0, it.data});
            end else begin
                chk("unexpected_valid_b", {31'h0, v_b}, 32'h0);
            end
        end else if (rdq_b.size() > 0 && rdq_b[0].cyc < cyc) begin
            void'(rdq_b.pop_front());
            chk("missing_valid_b", {31'h0, v_b}, 32'h1);
        end
        e = (errq_a.size() > 0 && errq_a[0] < cyc);
        if (e) void'(errq_a.pop_front());
        if (e || err_a) chk("erro_a", {31'h0, err_a}, {31'h0, e});
        e = (errq_b.size() > 0 && errq_b[0] < cyc);
        if (e) void'(errq_b.pop_front());
        if (e || err_b) chk("erro_b", {31'h0, err_b}, {31'h0, e});
    end

    // One clock of stimulus for both instances, with the reference model updated alongside.
    task automatic op(input bit we, input bit re, input bit clr, input int lbl, input logic [7:0] d,
                      input bit we16 = 1'b0, input bit re16 = 1'b0, input int lbl16 = 0,
                      input logic [15:0] d16 = 16'h0);
        label_a = lbl[7:0];  dado_a = d;   we_a = we;   re_a = re;   clr_a = clr;
        label_b = lbl16[7:0]; dado_b = d16; we_b = we16; re_b = re16; clr_b = 1'b0;
        if (left_a > 0) begin
            left_a--;
        end else if (clr) begin
            left_a = D8;
            foreach (mem_a[i]) mem_a[i] = 8'h00;
        end else begin
            if ((we || re) && lbl >= D8 && ERRO_EN) errq_a.push_back(cyc);
            if (re) rdq_a.push_back('{cyc, (lbl < D8) ? {8'h00, mem_a[lbl]} : 16'h0000});
            if (we && lbl < D8) mem_a[lbl] = d;
        end
        if (left_b > 0) begin
            left_b--;
        end else begin
            if ((we16 || re16) && lbl16 >= D16 && ERRO_EN) errq_b.push_back(cyc);
            if (re16) rdq_b.push_back('{cyc, (lbl16 < D16) ? mem_b[lbl16] : 16'h0000});
            if (we16 && lbl16 < D16) mem_b[lbl16] = d16;
        end
        @(posedge clk);
        #1;
        chk("ocupado_a", {31'h0, busy_a}, {31'h0, (left_a > 0)});
        chk("ocupado_b", {31'h0, busy_b}, {31'h0, (left_b > 0)});
    endtask

    task automatic idle();
        op(1'b0, 1'b0, 1'b0, 0, 8'h00);
    endtask

    task automatic do_reset(input int n);
        rdq_a.delete(); rdq_b.delete(); errq_a.delete(); errq_b.delete();
        reset = 1'b0;
        #1;
        chk("rst_q_a", {24'h0, q_a}, 32'h0);
        chk("rst_valid_a", {31'h0, v_a}, 32'h0);
        chk("rst_busy_a", {31'h0, busy_a}, 32'h1);
        chk("rst_erro_a", {31'h0, err_a}, 32'h0);
        chk("rst_q_b", {16'h0, q_b}, 32'h0);
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b1;
        left_a = D8;
        left_b = D16;
        foreach (mem_a[i]) mem_a[i] = 8'h00;
        foreach (mem_b[i]) mem_b[i] = 16'h0000;
    endtask

    task automatic sweep_len(input string nm);
        int n;
        n = 0;
        while (busy_a && n < 200) begin
            idle();
            n++;
        end
        chk(nm, n, D8);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        label_a = 8'h00; dado_a = 8'h00; we_a = 1'b0; re_a = 1'b0; clr_a = 1'b0;
        label_b = 8'h00; dado_b = 16'h0; we_b = 1'b0; re_b = 1'b0; clr_b = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 1: reset, sweep length, all words read zero
        do_reset(3);
        sweep_len("sweep_len_reset");
        for (int i = 0; i < D8; i++) op(1'b0, 1'b1, 1'b0, i, 8'h00);
        idle();

        // 2: write then read
        op(1'b1, 1'b0, 1'b0, 5, 8'hA5);
        op(1'b0, 1'b1, 1'b0, 5, 8'h00);
        idle();
        idle();

        // 3: read-before-write on the same address
        op(1'b1, 1'b0, 1'b0, 7, 8'h3C);
        op(1'b1, 1'b1, 1'b0, 7, 8'hC3);
        op(1'b0, 1'b1, 1'b0, 7, 8'h00);
        idle();

        // 4: fill, clear together with a write, requests ignored while busy
        for (int i = 0; i < D8; i++) op(1'b1, 1'b0, 1'b0, i, 8'($urandom_range(1, 255)));
        op(1'b1, 1'b0, 1'b1, 2, 8'hFF);
        for (int i = 0; i < D8; i++)
            op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 31), 8'($urandom));
        chk("busy_after_clear", {31'h0, busy_a}, 32'h0);
        for (int i = 0; i < D8; i++) op(1'b0, 1'b1, 1'b0, i, 8'h00);

        // 5: out-of-range write and read
        op(1'b1, 1'b0, 1'b0, 30, 8'h11);
        idle();
        op(1'b0, 1'b1, 1'b0, 30, 8'h00);
        idle();

        // Randomised traffic with occasional clears
        for (int i = 0; i < 300; i++)
            op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0),
               $urandom_range(0, 31), 8'($urandom));
        while (left_a > 0) idle();
        for (int i = 0; i < D8; i++) op(1'b0, 1'b1, 1'b0, i, 8'h00);

        // 6: reset during a sweep at address 10, then during a pending read
        op(1'b0, 1'b0, 1'b1, 0, 8'h00);
        repeat (10) idle();
        do_reset(2);
        sweep_len("sweep_len_midsweep");
        op(1'b1, 1'b0, 1'b0, 3, 8'h5A);
        op(1'b0, 1'b1, 1'b0, 3, 8'h00);
        chk("pre_rst_valid", {31'h0, v_a}, 32'h1);
        chk("pre_rst_data", {24'h0, q_a}, 32'h5A);
        do_reset(1);
        sweep_len("sweep_len_after_read");

        // Wide instance: round-trip at the last label and out-of-range access
        while (left_b > 0) idle();
        op(1'b0, 1'b0, 1'b0, 0, 8'h00, 1'b1, 1'b0, 63, 16'hBEEF);
        op(1'b0, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b1, 63, 16'h0000);
        op(1'b0, 1'b0, 1'b0, 0, 8'h00, 1'b1, 1'b0, 64, 16'h1234);
        op(1'b0, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b1, 64, 16'h0000);
        for (int i = 0; i < 40; i++)
            op(1'b0, 1'b0, 1'b0, 0, 8'h00, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 70), 16'($urandom));
        op(1'b0, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b1, 63, 16'h0000);
        idle();
        idle();

        chk("drain_a", rdq_a.size(), 32'h0);
        chk("drain_b", rdq_b.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/memoria_dados_param.md
Name: memoria_dados_param

Overview:
- Parametrised data memory for the processor datapath; generalises the fixed 24x8 data memory.
- Configurable data width, address width and depth.
- Synchronous write; registered read with a valid strobe.
- Hardware clear sweep, triggered by reset or by a clear command, with a busy flag. No file I/O at run time.

Parameters:
- LARGURA_DADO, 8, data word width in bits.
- LARGURA_END, 8, address (label) width in bits.
- PROFUNDIDADE, 24, number of words; must be ≤ 2^LARGURA_END and ≥ 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- label  input  LARGURA_END  word address.
- dado  input  LARGURA_DADO  write data.
- EscrMemo  input  1  write request.
- LerMemo  input  1  read request.
- limpar  input  1  clear request; single-cycle pulse is sufficient.
- dadoEscrito  output  LARGURA_DADO  registered read data.
- dado_valido  output  1  high for exactly one cycle when dadoEscrito is updated by a read.
- ocupado  output  1  clear sweep in progress; requests are ignored while high.
- erro  output  1  out-of-range access flag (only with MEMO_ERRO_EN; otherwise tied 0).

Behaviour:

Reset (reset low, asynchronous):
- State = LIMPANDO, sweep counter = 0.
- dadoEscrito = 0, dado_valido = 0, ocupado = 1, erro = 0.
- Array contents are not touched asynchronously; they are cleared by the sweep after reset releases.

State machine (two states):
- LIMPANDO:
  - Each clock writes 0 to Memo[cnt], then cnt increments.
  - On the cycle that writes cnt = PROFUNDIDADE-1, the next state is OCIOSO, and ocupado falls at that same edge.
  - The sweep takes exactly PROFUNDIDADE cycles after reset deassertion.
  - EscrMemo, LerMemo and limpar are ignored; dado_valido stays 0.
- OCIOSO, priority per cycle:
  - limpar = 1: go to LIMPANDO with cnt = 0. ocupado rises at the next edge. EscrMemo and LerMemo in that cycle are dropped.
  - Otherwise, EscrMemo: Memo[label] <= dado at the edge.
  - Otherwise, or concurrently with the write, LerMemo: dadoEscrito <= Memo[label] at the edge and dado_valido = 1 for one cycle. Read latency is 1 cycle.
  - Simultaneous EscrMemo and LerMemo to the same address is read-before-write: dadoEscrito returns the old contents and the new value is stored.
- dadoEscrito holds its last value when no read occurs. Reads and writes do not change the sweep counter.
- Reset asserted mid-sweep or mid-access: returns immediately to the reset values; the sweep restarts from address 0 after release.

Address range:
- Addresses ≥ PROFUNDIDADE: writes are ignored and reads return 0 with dado_valido = 1.
- Never index outside the array.

Widths:
- dado and dadoEscrito are exactly LARGURA_DADO bits; no sign handling.
- Sweep counter width is clog2(PROFUNDIDADE), minimum 1.

Optional Feature:
- Macro MEMO_ERRO_EN.
- Defined: erro is registered and goes high for one cycle, on the same edge where the access would complete, when EscrMemo or LerMemo is accepted in OCIOSO with label ≥ PROFUNDIDADE. Access is still suppressed as above. Cleared by reset.
- Undefined: no range-check flag logic; erro is constant 0. Out-of-range suppression still applies.

Test Plan:
1. Reset low 3 cycles, then high; default parameters: ocupado = 1 for exactly 24 cycles after release, then 0. Read every address 0..23: all return 0 with dado_valido pulsing once per read.
2. Write 8'hA5 to label 5, next cycle LerMemo label 5: dadoEscrito = 8'hA5, dado_valido = 1 exactly one cycle after the read request, then 0.
3. Location 7 holds 8'h3C; same cycle EscrMemo = 1, LerMemo = 1, label 7, dado 8'hC3: dadoEscrito = 8'h3C; a following read returns 8'hC3.
4. Fill addresses 0..23 with nonzero data, pulse limpar together with EscrMemo to label 2 (dado 8'hFF): ocupado high 24 cycles. Requests during the sweep are ignored. All addresses read 0 afterwards, including 2.
5. Built with MEMO_ERRO_EN, write 8'h11 to label 30: erro = 1 for one cycle, no array change, and a read of label 30 returns 0 with erro = 1. Without the macro, erro stays 0 throughout.
6. Assert reset at sweep address 10 and at a pending read: dado_valido = 0 and dadoEscrito = 0 immediately; the sweep restarts and takes 24 cycles. Instantiate with LARGURA_DADO = 16, PROFUNDIDADE = 64: 16'hBEEF write/read round-trips at label 63.
